// File: rtl/window_3x3_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// window_3x3_gen
//
// Builds the 3x3 sliding pixel window for the convolution stage from the
// three time-aligned row streams produced by two cascaded line buffers.
// Column and row position are tracked so that a window is only issued once
// three pixels of the current row have been collected. Windows that would
// mix the tail of one row with the head of the next are therefore never
// issued. The last window of each row is flagged with eol, and the last
// window of the frame is flagged with eof.
//
// Parameters
//   WIDTH       pixel bit width
//   IMG_WIDTH   pixels per image row (3..511)
//   IMG_HEIGHT  rows per frame (3..511)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din_top    pixel of row r-2 (second line-buffer output)
//   din_mid    pixel of row r-1 (first line-buffer output)
//   din_bot    pixel of row r (raw stream)
//   valid_in   all three row pixels valid this cycle
//   win        3x3 window, element (r,c) at [WIDTH*(3*r+c) +: WIDTH],
//              r=0 top row, c=0 oldest/leftmost column
//   valid_out  one-cycle pulse: win holds a complete in-row window
//   eol        with valid_out: last window of a row
//   eof        with valid_out: last window of the frame
//   busy       a frame is in progress
// ---------------------------------------------------------------------------
module window_3x3_gen #(
  parameter int WIDTH      = 10,
  parameter int IMG_WIDTH  = 480,
  parameter int IMG_HEIGHT = 320
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din_top,
  input  logic [WIDTH-1:0]     din_mid,
  input  logic [WIDTH-1:0]     din_bot,
  input  logic                 valid_in,
  output logic [9*WIDTH-1:0]   win,
  output logic                 valid_out,
  output logic                 eol,
  output logic                 eof,
  output logic                 busy
);

  localparam logic [8:0] COL_LAST = 9'(IMG_WIDTH - 1);
  // The row counter counts row triplets: a frame of IMG_HEIGHT rows
  // yields IMG_HEIGHT-2 output rows.
  localparam logic [8:0] ROW_LAST = 9'(IMG_HEIGHT - 3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [8:0]                col;
  logic [8:0]                row;

  // Column shift registers, element 2 is the newest pixel.
  logic [2:0][WIDTH-1:0]     top_p0;
  logic [2:0][WIDTH-1:0]     mid_p0;
  logic [2:0][WIDTH-1:0]     bot_p0;
  logic [2:0][WIDTH-1:0]     top_nxt;
  logic [2:0][WIDTH-1:0]     mid_nxt;
  logic [2:0][WIDTH-1:0]     bot_nxt;

  logic [9*WIDTH-1:0]        win_p1;
  logic                      vld_p1;
  logic                      eol_p1;
  logic                      eof_p1;
  logic                      busy_p1;

  logic                      col_last;
  logic                      row_last;
  logic                      win_ok;

  // Packed element c of each row register sits at bits [WIDTH*c], so
  // stacking bot/mid/top gives the (r,c) layout with r=0 at the bottom bits.
  function automatic logic [9*WIDTH-1:0] pack_window(
    input logic [2:0][WIDTH-1:0] t,
    input logic [2:0][WIDTH-1:0] m,
    input logic [2:0][WIDTH-1:0] b
  );
    return {b, m, t};
  endfunction

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  // The first two pixels of a row only fill the column registers; any
  // window before that would still hold previous-row pixels.
  assign win_ok   = (col >= 9'd2);

  always_comb begin
    top_nxt = {din_top, top_p0[2], top_p0[1]};
    mid_nxt = {din_mid, mid_p0[2], mid_p0[1]};
    bot_nxt = {din_bot, bot_p0[2], bot_p0[1]};
  end

  always_comb begin
    state_nxt = state;
    if (valid_in) begin
      unique case (state)
        IDLE: state_nxt = FILL;
        FILL: if (col == 9'd1) state_nxt = RUN;
        RUN: begin
          if (col_last) state_nxt = row_last ? IDLE : FILL;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: shift columns, track position, register window ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      top_p0  <= '0;
      mid_p0  <= '0;
      bot_p0  <= '0;
      win_p1  <= '0;
      vld_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      eof_p1  <= 1'b0;
      busy_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy_p1 <= (state_nxt != IDLE);
      vld_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      eof_p1  <= 1'b0;
      if (valid_in) begin
        top_p0 <= top_nxt;
        mid_p0 <= mid_nxt;
        bot_p0 <= bot_nxt;
        if (win_ok) begin
          win_p1 <= pack_window(top_nxt, mid_nxt, bot_nxt);
          vld_p1 <= 1'b1;
          eol_p1 <= col_last;
          eof_p1 <= col_last && row_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? 9'd0 : row + 9'd1;
        end else begin
          col <= col + 9'd1;
        end
      end
    end
  end

  assign win       = win_p1;
  assign valid_out = vld_p1;
  assign eol       = eol_p1;
  assign eof       = eof_p1;
  assign busy      = busy_p1;

endmodule

// File: tb/tb_window_3x3_gen.sv
`timescale 1ns/1ps
module tb_window_3x3_gen;

  localparam int W  = 10;
  localparam int IW = 8;
  localparam int IH = 5;
  localparam int NT = IH - 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    din_top, din_mid, din_bot;
  logic            valid_in;
  logic [9*W-1:0]  win;
  logic            valid_out, eol, eof, busy;

  int checks = 0;
  int failures = 0;
  int nwin, neol, neof;
  logic [9*W-1:0] last_win;
  logic           exp_busy;

  window_3x3_gen #(.WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk(clk), .rst(rst),
    .din_top(din_top), .din_mid(din_mid), .din_bot(din_bot),
    .valid_in(valid_in),
    .win(win), .valid_out(valid_out), .eol(eol), .eof(eof), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window for triplet row t, accepted column c (c>=2): element (r,cc) is
  // pixel 16*(t+r) + (c-2+cc).
  function automatic logic [9*W-1:0] exp_win(input int t, input int c);
    logic [9*W-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int cc = 0; cc < 3; cc++)
        w[W*(3*r+cc) +: W] = W'(16*(t+r) + c - 2 + cc);
    return w;
  endfunction

  task automatic step_pix(input int t, input int c);
    din_top  = W'(16*t + c);
    din_mid  = W'(16*(t+1) + c);
    din_bot  = W'(16*(t+2) + c);
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (c >= 2) last_win = exp_win(t, c);
    exp_busy = !(t == NT-1 && c == IW-1);
    chk($sformatf("valid_out t%0d c%0d", t, c), 128'(valid_out), 128'(c >= 2));
    chk($sformatf("win t%0d c%0d", t, c), 128'(win), 128'(last_win));
    chk($sformatf("eol t%0d c%0d", t, c), 128'(eol), 128'(c == IW-1));
    chk($sformatf("eof t%0d c%0d", t, c), 128'(eof), 128'(c == IW-1 && t == NT-1));
    chk($sformatf("busy t%0d c%0d", t, c), 128'(busy), 128'(exp_busy));
    nwin += int'(valid_out);
    neol += int'(eol);
    neof += int'(eof);
  endtask

  task automatic idle_cycle();
    din_top  = W'($urandom_range(0, 1023));
    din_mid  = W'($urandom_range(0, 1023));
    din_bot  = W'($urandom_range(0, 1023));
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("gap valid_out", 128'(valid_out), 128'(0));
    chk("gap win_hold", 128'(win), 128'(last_win));
    chk("gap busy", 128'(busy), 128'(exp_busy));
  endtask

  task automatic frame(input int max_gap);
    for (int t = 0; t < NT; t++)
      for (int c = 0; c < IW; c++) begin
        int g;
        step_pix(t, c);
        g = (max_gap == 0) ? 0 : ((c % 2 == 0) ? 1 : $urandom_range(0, max_gap));
        repeat (g) idle_cycle();
      end
  endtask

  task automatic check_counts(input string tag, input int ew, input int el, input int ef);
    chk({tag, " windows"}, 128'(nwin), 128'(ew));
    chk({tag, " eol_count"}, 128'(neol), 128'(el));
    chk({tag, " eof_count"}, 128'(neof), 128'(ef));
    nwin = 0; neol = 0; neof = 0;
  endtask

  initial begin
    nwin = 0; neol = 0; neof = 0;
    last_win = '0;
    exp_busy = 1'b0;
    rst = 1'b1;
    valid_in = 1'b0;
    din_top = '0; din_mid = '0; din_bot = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset win", 128'(win), 128'(0));
    chk("reset valid_out", 128'(valid_out), 128'(0));
    chk("reset eol", 128'(eol), 128'(0));
    chk("reset eof", 128'(eof), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    rst = 1'b0;
    idle_cycle();

    // Continuous frame, includes the row-boundary cases.
    frame(0);
    check_counts("cont", 18, 3, 1);
    idle_cycle();

    // Same frame with gaps between accepted pixels.
    frame(3);
    check_counts("gaps", 18, 3, 1);
    idle_cycle();

    // Two frames back-to-back with no idle cycle in between.
    frame(0);
    frame(0);
    check_counts("b2b", 36, 6, 2);
    idle_cycle();

    // Reset in the middle of a frame, with valid_in asserted during reset.
    for (int i = 0; i < 20; i++) step_pix(i / IW, i % IW);
    nwin = 0; neol = 0; neof = 0;
    rst = 1'b1;
    valid_in = 1'b1;
    din_top = 10'h3ff; din_mid = 10'h155; din_bot = 10'h2aa;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_in = 1'b0;
    chk("midrst win", 128'(win), 128'(0));
    chk("midrst valid_out", 128'(valid_out), 128'(0));
    chk("midrst eol", 128'(eol), 128'(0));
    chk("midrst eof", 128'(eof), 128'(0));
    chk("midrst busy", 128'(busy), 128'(0));
    last_win = '0;
    exp_busy = 1'b0;
    idle_cycle();
    frame(0);
    check_counts("after_rst", 18, 3, 1);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
